ux607_icb_perips_split: RTL
===========================

# ux607_icb_perips_split

Single-master ICB splitter that sits directly upstream of the peripheral top-level wrappers (PWM8 instances and siblings), fanning one ICB port out to N peripheral ICB ports by address decode. It tracks outstanding transactions in a small ID FIFO so that responses return to the master in command order. Unmapped addresses are answered internally with an error response. Peripheral ports carry no error signal; only the master port does.

## Interface
- N_SLV, 4, number of peripheral ports
- OUTS_DEPTH, 2, maximum outstanding commands (power of 2, ≥1)
- SLV_BASE, {N_SLV{`UX607_PA_SIZE'h0}}, flat base addresses; slot k is bits [k*PA +: PA]
- SLV_MASK, {N_SLV{`UX607_PA_SIZE'h0}}, flat decode masks; same packing

- clk  in  1  clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- i_icb_cmd_valid / i_icb_cmd_ready  in/out  1/1  master command handshake
- i_icb_cmd_addr  in  `UX607_PA_SIZE  command address
- i_icb_cmd_read  in  1  1 = read
- i_icb_cmd_wdata  in  32  write data
- i_icb_rsp_valid / i_icb_rsp_ready  out/in  1/1  master response handshake
- i_icb_rsp_rdata  out  32  read data
- i_icb_rsp_err  out  1  1 = decode miss
- o_icb_cmd_valid / o_icb_cmd_ready  out/in  N_SLV/N_SLV  per-peripheral command handshake
- o_icb_cmd_addr, o_icb_cmd_read, o_icb_cmd_wdata  out  PA/1/32  broadcast to all peripherals
- o_icb_rsp_valid / o_icb_rsp_ready  in/out  N_SLV/N_SLV  per-peripheral response handshake
- o_icb_rsp_rdata  in  N_SLV*32  flat per-peripheral read data

## Operation
- Decode: slot k hits when (addr & SLV_MASK[k]) == SLV_BASE[k]. The lowest hitting index wins. If no slot hits, the command targets ID = N_SLV (the internal error target).
- ID FIFO: depth OUTS_DEPTH, entries ID_W = $clog2(N_SLV+1) bits wide. It is full when count == OUTS_DEPTH.
- Command path (combinational):
  - o_icb_cmd_valid[k] = i_icb_cmd_valid & sel==k & ~full.
  - i_icb_cmd_ready = ~full & (miss | o_icb_cmd_ready[sel]).
  - On a master cmd handshake, the target ID is pushed.
  - The command valid never depends on the peripheral ready.
- Response path:
  - Only the FIFO head target is serviced.
  - o_icb_rsp_ready[k] = ~empty & head==k & i_icb_rsp_ready.
  - i_icb_rsp_valid = ~empty & (head==N_SLV ? 1 : o_icb_rsp_valid[head]).
  - rdata is muxed from the head target.
  - For the error target: rdata = 0 and err = 1. err is 0 otherwise.
  - A master rsp handshake pops the head.
- A response from a non-head peripheral is held off (its ready = 0) until that peripheral reaches the head. This enforces in-order return.
- Simultaneous push and pop:
  - allowed when not full; count is unchanged.
  - When full, push is blocked in that cycle even if a pop occurs.
- Wrap-around: read and write pointers are ID-FIFO-index wide and wrap naturally. count is $clog2(OUTS_DEPTH)+1 bits.

## Timing
- Reset values (rst_n low, asynchronous):
  - FIFO empty, pointers 0, count 0.
  - i_icb_rsp_valid = 0, all o_icb_rsp_ready = 0.
  - i_icb_cmd_ready and o_icb_cmd_valid follow their combinational equations with full = 0.
- Command latency: 0 cycles (combinational pass-through).
- Response latency:
  - Peripheral rsp to master rsp: 0 cycles once the target is at the head.
  - Error response: valid no earlier than the cycle after the command is accepted.
- Pop takes effect at the clock edge after the handshake, and the next head is visible in the following cycle. Back-to-back responses are therefore possible every cycle.
- Reset mid-transaction: all outstanding IDs are discarded. Peripherals are reset by the same rst_n.

## Structure
- Package ux607_icb_pkg holds:
  - ICB_DW = 32
  - function clog2
  - the ID-width helper
- Sub-module ux607_icb_id_fifo: parameterised sync FIFO (DEPTH, DW) with push/pop/full/empty/head, using the async active-low reset. The splitter instantiates it with DW = ID_W.

## Test plan
- Single write to slot 1 (base 0x1000_2000, mask 0xFFFF_F000), addr 0x1000_2004, wdata 0xA5A5_0001: only o_icb_cmd_valid[1] is asserted; the rsp is passed through with err = 0.
- Read from an unmapped address 0x2000_0000: the command is accepted without any peripheral valid. The next cycle gives rsp_valid = 1, rdata = 0, err = 1.
- Cmd to slot 2, then slot 0; slot 0 responds first (rdata 0x11) and slot 2 responds three cycles later (0x22):
  - the master receives 0x22 then 0x11;
  - o_icb_rsp_ready[0] stays 0 until slot 2 is popped.
- Back-to-back commands with OUTS_DEPTH = 2 and i_icb_rsp_ready = 0: the third command sees i_icb_cmd_ready = 0. Raising rsp_ready frees one slot the following cycle.
- Overlapping decode (slots 0 and 3 both hit 0x1000_0000): only slot 0 is selected.
- Assert rst_n = 0 with 2 outstanding, then release: rsp_valid = 0 and the FIFO is empty. A new command is accepted on the first cycle after release.

Source files
------------

// File: rtl/ux607_icb_pkg.sv
// ux607_icb_pkg: shared constants and width helpers for the ICB peripheral
// splitter and its ID FIFO.
//   ICB_DW   - ICB data bus width
//   clog2    - ceiling log2 (clog2(1) = 0)
//   id_width - bits needed to name N peripheral targets plus the error target
`ifndef UX607_PA_SIZE
`define UX607_PA_SIZE 32
`endif

package ux607_icb_pkg;

   localparam int ICB_DW = 32;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   // Targets 0..n-1 are peripherals; target n is the internal error responder.
   function automatic int id_width(input int n_slv);
      return clog2(n_slv + 1);
   endfunction

endpackage

// File: rtl/ux607_icb_id_fifo.sv
// ux607_icb_id_fifo: small synchronous FIFO holding the target ID of every
// outstanding ICB command, in command order.
//   clk, rst_n - clock, asynchronous active-low reset (control state only)
//   push, din  - write request and data; ignored while full
//   pop        - read request; ignored while empty
//   full/empty - occupancy flags
//   head       - oldest entry (valid only when not empty)
module ux607_icb_id_fifo
   import ux607_icb_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int DW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [DW-1:0] head
);

   localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
   localparam int CW = clog2(DEPTH) + 1;

   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] count;
   logic [DW-1:0] mem [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
         if (do_pop)  rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

endmodule

// File: rtl/ux607_icb_perips_split.sv
// ux607_icb_perips_split: one ICB master port fanned out to N_SLV peripheral
// ICB ports by address decode. Responses return in command order; addresses
// that hit no peripheral are answered internally with err = 1, rdata = 0.
//   i_icb_cmd_*  - master command (valid/ready/addr/read/wdata)
//   i_icb_rsp_*  - master response (valid/ready/rdata/err)
//   o_icb_cmd_*  - per-peripheral valid/ready; addr/read/wdata broadcast
//   o_icb_rsp_*  - per-peripheral valid/ready; flat per-peripheral rdata
module ux607_icb_perips_split
   import ux607_icb_pkg::*;
#(
   parameter int N_SLV      = 4,
   parameter int OUTS_DEPTH = 2,
   parameter logic [N_SLV*`UX607_PA_SIZE-1:0] SLV_BASE = {N_SLV{`UX607_PA_SIZE'h0}},
   parameter logic [N_SLV*`UX607_PA_SIZE-1:0] SLV_MASK = {N_SLV{`UX607_PA_SIZE'h0}}
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_icb_cmd_valid,
   output logic                      i_icb_cmd_ready,
   input  logic [`UX607_PA_SIZE-1:0] i_icb_cmd_addr,
   input  logic                      i_icb_cmd_read,
   input  logic [ICB_DW-1:0]         i_icb_cmd_wdata,
   output logic                      i_icb_rsp_valid,
   input  logic                      i_icb_rsp_ready,
   output logic [ICB_DW-1:0]         i_icb_rsp_rdata,
   output logic                      i_icb_rsp_err,
   output logic [N_SLV-1:0]          o_icb_cmd_valid,
   input  logic [N_SLV-1:0]          o_icb_cmd_ready,
   output logic [`UX607_PA_SIZE-1:0] o_icb_cmd_addr,
   output logic                      o_icb_cmd_read,
   output logic [ICB_DW-1:0]         o_icb_cmd_wdata,
   input  logic [N_SLV-1:0]          o_icb_rsp_valid,
   output logic [N_SLV-1:0]          o_icb_rsp_ready,
   input  logic [N_SLV*ICB_DW-1:0]   o_icb_rsp_rdata
);

   localparam int PA   = `UX607_PA_SIZE;
   localparam int ID_W = id_width(N_SLV);
   localparam logic [ID_W-1:0] ERR_ID = ID_W'(N_SLV);

   logic [ID_W-1:0]   sel;
   logic              miss;
   logic              tgt_ready;
   logic              full;
   logic              empty;
   logic [ID_W-1:0]   head;
   logic              head_err;
   logic              head_valid;
   logic [ICB_DW-1:0] head_rdata;
   logic              push;
   logic              pop;

   // Descending scan so the lowest hitting slot overrides the others.
   always_comb begin
      sel = ERR_ID;
      for (int k = N_SLV - 1; k >= 0; k--) begin
         if ((i_icb_cmd_addr & SLV_MASK[k*PA +: PA]) == SLV_BASE[k*PA +: PA])
            sel = ID_W'(k);
      end
   end

   assign miss = (sel == ERR_ID);

   // Command valid deliberately ignores peripheral ready (no valid->ready loop).
   always_comb begin
      tgt_ready       = 1'b0;
      o_icb_cmd_valid = '0;
      for (int k = 0; k < N_SLV; k++) begin
         if (sel == ID_W'(k)) begin
            tgt_ready          = o_icb_cmd_ready[k];
            o_icb_cmd_valid[k] = i_icb_cmd_valid & ~full;
         end
      end
   end

   assign i_icb_cmd_ready = ~full & (miss | tgt_ready);
   assign o_icb_cmd_addr  = i_icb_cmd_addr;
   assign o_icb_cmd_read  = i_icb_cmd_read;
   assign o_icb_cmd_wdata = i_icb_cmd_wdata;

   // Only the head target may respond; later targets wait their turn.
   always_comb begin
      head_valid      = 1'b0;
      head_rdata      = '0;
      o_icb_rsp_ready = '0;
      for (int k = 0; k < N_SLV; k++) begin
         if (head == ID_W'(k)) begin
            head_valid         = o_icb_rsp_valid[k];
            head_rdata         = o_icb_rsp_rdata[k*ICB_DW +: ICB_DW];
            o_icb_rsp_ready[k] = ~empty & i_icb_rsp_ready;
         end
      end
   end

   assign head_err        = (head == ERR_ID);
   assign i_icb_rsp_valid = ~empty & (head_err | head_valid);
   assign i_icb_rsp_rdata = head_rdata;
   assign i_icb_rsp_err   = ~empty & head_err;

   assign push = i_icb_cmd_valid & i_icb_cmd_ready;
   assign pop  = i_icb_rsp_valid & i_icb_rsp_ready;

   ux607_icb_id_fifo #(
      .DEPTH (OUTS_DEPTH),
      .DW    (ID_W)
   ) u_id_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (sel),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

endmodule
